// File: rtl/mesi_bus_ctrl.sv
// Bus-side MESI transaction controller: request queue, arbitration, address/snoop/data phases, snoop forwarding.
// Optional grant-wait timeout is compiled in when MESI_BUS_TIMEOUT_EN is defined.
module mesi_bus_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SNOOP_WAIT = 2,
    parameter int BEATS      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_rdx,
    input  logic              req_upgr,
    input  logic              req_flush,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_valid,
    output logic [2:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              snoop_hit,
    input  logic              snoop_hitm,
    input  logic              bus_dvalid_in,
    output logic              bus_dvalid_out,
    input  logic              snp_valid,
    input  logic [2:0]        snp_cmd,
    output logic              snp_rd,
    output logic              snp_rdx,
    output logic              snp_upgr,
    output logic              c_out,
    output logic              done,
    output logic              busy,
    output logic              err
);
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_RWIM  = 3'd2;
    localparam logic [2:0] CMD_INV   = 3'd3;
    localparam logic [2:0] CMD_WRITE = 3'd4;

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int SW_W = $clog2(SNOOP_WAIT + 1);
    localparam int BT_W = $clog2(BEATS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_SNOOP, S_DATA, S_DONE} state_e;

    // Request queue: extra pointer bit distinguishes full from empty
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]        cmd_mem_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic              fifo_empty, fifo_full, push, pop;
    logic [2:0]        push_cmd, head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic              arb_timeout;

    always_comb begin
        push_cmd = CMD_IDLE;
        if (req_flush)     push_cmd = CMD_WRITE;
        else if (req_rdx)  push_cmd = CMD_RWIM;
        else if (req_upgr) push_cmd = CMD_INV;
        else if (req_rd)   push_cmd = CMD_READ;
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = (req_rd | req_rdx | req_upgr | req_flush) && !fifo_full;
    assign head_cmd   = cmd_mem_q[rd_ptr_q[PW-1:0]];
    assign head_addr  = addr_mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q[PW-1:0]]  <= push_cmd;
            addr_mem_q[wr_ptr_q[PW-1:0]] <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    state_e            state_q;
    logic              bus_req_q, bus_valid_q, bus_dvalid_out_q;
    logic [2:0]        bus_cmd_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              done_q, c_out_q, err_q, shared_q;
    logic [SW_W-1:0]   snp_cnt_q;
    logic [BT_W-1:0]   beat_cnt_q;
    logic              head_is_rd;

    assign head_is_rd = (head_cmd == CMD_READ) || (head_cmd == CMD_RWIM);

`ifdef MESI_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] arb_cnt_q;

    assign arb_timeout = (state_q == S_ARB) && !(bus_req_q && bus_gnt)
                         && (arb_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != S_ARB) arb_cnt_q <= '0;
        else if (!arb_timeout)       arb_cnt_q <= arb_cnt_q + TW'(1);
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign arb_timeout    = 1'b0;
`endif

    // A timed-out request is discarded just like a completed one
    assign pop = (state_q == S_DONE) || arb_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            bus_req_q        <= 1'b0;
            bus_valid_q      <= 1'b0;
            bus_cmd_q        <= CMD_IDLE;
            bus_addr_q       <= '0;
            bus_dvalid_out_q <= 1'b0;
            done_q           <= 1'b0;
            c_out_q          <= 1'b0;
            err_q            <= 1'b0;
            shared_q         <= 1'b0;
            snp_cnt_q        <= '0;
            beat_cnt_q       <= '0;
        end else begin
            bus_valid_q      <= 1'b0;
            bus_cmd_q        <= CMD_IDLE;
            bus_addr_q       <= '0;
            bus_dvalid_out_q <= 1'b0;
            done_q           <= 1'b0;
            c_out_q          <= 1'b0;
            err_q            <= arb_timeout;
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= S_ARB;
                        bus_req_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    // Grant only counts while our request is visible (not in the retry gap)
                    if (bus_req_q && bus_gnt) begin
                        state_q     <= S_ADDR;
                        bus_valid_q <= 1'b1;
                        bus_cmd_q   <= head_cmd;
                        bus_addr_q  <= head_addr;
                    end else if (arb_timeout) begin
                        state_q   <= S_IDLE;
                        bus_req_q <= 1'b0;
                    end else begin
                        bus_req_q <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state_q   <= S_SNOOP;
                    snp_cnt_q <= '0;
                end
                S_SNOOP: begin
                    if (snp_cnt_q == SW_W'(SNOOP_WAIT - 1)) begin
                        beat_cnt_q <= '0;
                        if (head_is_rd && snoop_hitm) begin
                            state_q   <= S_ARB;
                            bus_req_q <= 1'b0;
                        end else begin
                            shared_q <= (head_cmd == CMD_READ) && (snoop_hit || snoop_hitm);
                            if (head_cmd == CMD_INV) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                bus_req_q <= 1'b0;
                            end else begin
                                state_q          <= S_DATA;
                                bus_dvalid_out_q <= (head_cmd == CMD_WRITE);
                            end
                        end
                    end else begin
                        snp_cnt_q <= snp_cnt_q + SW_W'(1);
                    end
                end
                S_DATA: begin
                    // Writes stream every cycle; reads advance only on incoming beats
                    if (head_cmd == CMD_WRITE || bus_dvalid_in) begin
                        if (beat_cnt_q == BT_W'(BEATS - 1)) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            c_out_q   <= shared_q;
                            bus_req_q <= 1'b0;
                        end else begin
                            beat_cnt_q       <= beat_cnt_q + BT_W'(1);
                            bus_dvalid_out_q <= (head_cmd == CMD_WRITE);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic snp_rd_q, snp_rdx_q, snp_upgr_q, fwd;
    assign fwd = snp_valid && !bus_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            snp_rd_q   <= 1'b0;
            snp_rdx_q  <= 1'b0;
            snp_upgr_q <= 1'b0;
        end else begin
            snp_rd_q   <= fwd && (snp_cmd == CMD_READ);
            snp_rdx_q  <= fwd && (snp_cmd == CMD_RWIM);
            snp_upgr_q <= fwd && (snp_cmd == CMD_INV);
        end
    end

    assign req_ready      = !fifo_full;
    assign bus_req        = bus_req_q;
    assign bus_valid      = bus_valid_q;
    assign bus_cmd        = bus_cmd_q;
    assign bus_addr       = bus_addr_q;
    assign bus_dvalid_out = bus_dvalid_out_q;
    assign snp_rd         = snp_rd_q;
    assign snp_rdx        = snp_rdx_q;
    assign snp_upgr       = snp_upgr_q;
    assign c_out          = c_out_q;
    assign done           = done_q;
    assign busy           = (state_q != S_IDLE) || !fifo_empty;
    assign err            = err_q;
endmodule
